// File: rtl/cache_set_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_set_controller_if                                                    |
// | CPU request, way-array and memory signals for one cache set controller.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface cache_set_controller_if #(
  parameter int NUM_WAYS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  localparam int WORDS = BLOCK_SIZE / (DATA_WIDTH / 8);
  localparam int OW    = $clog2(WORDS);
  localparam int TW    = ADDRESS_WIDTH - OW;
  localparam int CW    = $clog2(NUM_WAYS);
  localparam int LW    = WORDS * DATA_WIDTH;

  logic                           req_valid;
  logic                           req_ready;
  logic                           req_we;
  logic [ADDRESS_WIDTH-1:0]       req_addr;
  logic [DATA_WIDTH-1:0]          req_wdata;
  logic                           resp_valid;
  logic [DATA_WIDTH-1:0]          resp_rdata;
  logic [NUM_WAYS-1:0]            way_valid;
  logic [NUM_WAYS-1:0]            way_dirty;
  logic [NUM_WAYS-1:0]            way_expired;
  logic [NUM_WAYS-1:0]            way_w_ack;
  logic [NUM_WAYS*TW-1:0]         way_tag;
  logic [NUM_WAYS*CW-1:0]         way_age;
  logic [NUM_WAYS*DATA_WIDTH-1:0] way_rdata;
  logic [NUM_WAYS*LW-1:0]         way_line;
  logic [NUM_WAYS-1:0]            way_allocate;
  logic [NUM_WAYS-1:0]            way_w_en;
  logic [OW-1:0]                  way_offset;
  logic [DATA_WIDTH-1:0]          way_wdata;
  logic [ADDRESS_WIDTH-1:0]       way_line_address;
  logic [LW-1:0]                  way_fetched_line;
  logic                           update_age;
  logic                           accessed;
  logic [CW-1:0]                  accessed_way_age;
  logic                           mem_req;
  logic                           mem_we;
  logic [ADDRESS_WIDTH-1:0]       mem_addr;
  logic [LW-1:0]                  mem_wline;
  logic                           mem_ack;
  logic [LW-1:0]                  mem_rline;

  // Controller side.
  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    input  way_valid, way_dirty, way_expired, way_w_ack, way_tag, way_age, way_rdata, way_line,
    input  mem_ack, mem_rline,
    output req_ready, resp_valid, resp_rdata,
    output way_allocate, way_w_en, way_offset, way_wdata, way_line_address, way_fetched_line,
    output update_age, accessed, accessed_way_age,
    output mem_req, mem_we, mem_addr, mem_wline
  );

  // CPU, way array and memory side.
  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    output way_valid, way_dirty, way_expired, way_w_ack, way_tag, way_age, way_rdata, way_line,
    output mem_ack, mem_rline,
    input  req_ready, resp_valid, resp_rdata,
    input  way_allocate, way_w_en, way_offset, way_wdata, way_line_address, way_fetched_line,
    input  update_age, accessed, accessed_way_age,
    input  mem_req, mem_we, mem_addr, mem_wline
  );
endinterface
`default_nettype wire

// File: rtl/cache_set_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_set_controller                                                       |
// | Single-set cache controller: lookup, write, writeback, refill, allocate.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cache_set_controller #(
  parameter int NUM_WAYS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  wire logic              clk,
  input  wire logic              reset,
  cache_set_controller_if.master bus
);
  localparam int WORDS = BLOCK_SIZE / (DATA_WIDTH / 8);
  localparam int OW    = $clog2(WORDS);
  localparam int TW    = ADDRESS_WIDTH - OW;
  localparam int CW    = $clog2(NUM_WAYS);
  localparam int LW    = WORDS * DATA_WIDTH;

  localparam logic [2:0] c_idle      = 3'd0;
  localparam logic [2:0] c_lookup    = 3'd1;
  localparam logic [2:0] c_write     = 3'd2;
  localparam logic [2:0] c_writeback = 3'd3;
  localparam logic [2:0] c_refill    = 3'd4;
  localparam logic [2:0] c_allocate  = 3'd5;
  localparam logic [2:0] c_respond   = 3'd6;

  logic [2:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_we;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [LW-1:0]            r_line;
  logic [TW-1:0]            r_vtag;
  logic [CW-1:0]            r_way;

  logic [TW-1:0]            w_tag;
  logic                     w_hit;
  logic [CW-1:0]            w_hit_way;
  logic                     w_inv;
  logic [CW-1:0]            w_inv_way;
  logic                     w_exp;
  logic [CW-1:0]            w_exp_way;
  logic [CW-1:0]            w_victim;
  logic                     w_victim_dirty;
  logic [CW-1:0]            w_age_way;
  logic [NUM_WAYS-1:0]      w_way_1h;
  logic                     w_update;

  assign w_tag = r_addr[ADDRESS_WIDTH-1:OW];

  // Descending scan so the lowest matching index wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_inv_way = '0;
    w_exp     = 1'b0;
    w_exp_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (bus.way_valid[i] && (bus.way_tag[i*TW +: TW] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = CW'(i);
      end
      if (!bus.way_valid[i]) begin
        w_inv     = 1'b1;
        w_inv_way = CW'(i);
      end
      if (bus.way_expired[i]) begin
        w_exp     = 1'b1;
        w_exp_way = CW'(i);
      end
    end
  end

  assign w_victim       = w_inv ? w_inv_way : (w_exp ? w_exp_way : '0);
  assign w_victim_dirty = bus.way_valid[w_victim] & bus.way_dirty[w_victim];
  assign w_age_way      = (r_state == c_lookup) ? w_hit_way : r_way;
  assign w_way_1h       = {{(NUM_WAYS-1){1'b0}}, 1'b1} << r_way;
  assign w_update       = ((r_state == c_lookup) & w_hit & ~r_we) |
                          ((r_state == c_write) & bus.way_w_ack[r_way]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_idle;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_line  <= '0;
      r_vtag  <= '0;
      r_way   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.req_valid) begin
            r_addr  <= bus.req_addr;
            r_we    <= bus.req_we;
            r_wdata <= bus.req_wdata;
            r_state <= c_lookup;
          end
        end
        c_lookup: begin
          if (w_hit) begin
            r_way <= w_hit_way;
            if (r_we) begin
              r_state <= c_write;
            end else begin
              r_rdata <= bus.way_rdata[w_hit_way*DATA_WIDTH +: DATA_WIDTH];
              r_state <= c_respond;
            end
          end else begin
            // Victim tag and line are snapshotted so writeback stays stable.
            r_way   <= w_victim;
            r_vtag  <= bus.way_tag[w_victim*TW +: TW];
            r_line  <= bus.way_line[w_victim*LW +: LW];
            r_state <= w_victim_dirty ? c_writeback : c_refill;
          end
        end
        c_write: begin
          if (bus.way_w_ack[r_way]) r_state <= c_respond;
        end
        c_writeback: begin
          if (bus.mem_ack) r_state <= c_refill;
        end
        c_refill: begin
          if (bus.mem_ack) begin
            r_line  <= bus.mem_rline;
            r_state <= c_allocate;
          end
        end
        c_allocate: r_state <= c_lookup;
        c_respond:  r_state <= c_idle;
        default:    r_state <= c_idle;
      endcase
    end
  end

  assign bus.req_ready        = (r_state == c_idle);
  assign bus.resp_valid       = (r_state == c_respond);
  assign bus.resp_rdata       = (r_state == c_respond) ? (r_we ? r_wdata : r_rdata) : '0;
  assign bus.way_w_en         = (r_state == c_write) ? w_way_1h : '0;
  assign bus.way_allocate     = (r_state == c_allocate) ? w_way_1h : '0;
  assign bus.way_offset       = (r_state != c_idle) ? r_addr[OW-1:0] : '0;
  assign bus.way_wdata        = (r_state != c_idle) ? r_wdata : '0;
  assign bus.way_line_address = (r_state == c_allocate) ? {w_tag, {OW{1'b0}}} : '0;
  assign bus.way_fetched_line = (r_state == c_allocate) ? r_line : '0;
  assign bus.update_age       = w_update;
  assign bus.accessed         = w_update;
  assign bus.accessed_way_age = w_update ? bus.way_age[w_age_way*CW +: CW] : '0;
  assign bus.mem_req          = (r_state == c_writeback) | (r_state == c_refill);
  assign bus.mem_we           = (r_state == c_writeback);
  assign bus.mem_addr         = (r_state == c_writeback) ? {r_vtag, {OW{1'b0}}} :
                                (r_state == c_refill)    ? {w_tag, {OW{1'b0}}}  : '0;
  assign bus.mem_wline        = (r_state == c_writeback) ? r_line : '0;

endmodule
`default_nettype wire

// File: tb/tb_cache_set_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cache_set_controller                                                    |
// | Directed self-checking bench with a behavioural way array and memory.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cache_set_controller;
  localparam int NW    = 4;
  localparam int DW    = 32;
  localparam int BS    = 32;
  localparam int AW    = 32;
  localparam int WORDS = BS / (DW / 8);
  localparam int OW    = $clog2(WORDS);
  localparam int TW    = AW - OW;
  localparam int CW    = $clog2(NW);
  localparam int LW    = WORDS * DW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_set_controller_if #(.NUM_WAYS(NW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .ADDRESS_WIDTH(AW)) bus ();
  cache_set_controller #(.NUM_WAYS(NW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .ADDRESS_WIDTH(AW))
    dut (.clk(clk), .reset(reset), .bus(bus));

  logic [NW-1:0] m_valid, m_dirty, m_expired;
  logic [TW-1:0] m_tag  [NW];
  logic [CW-1:0] m_age  [NW];
  logic [LW-1:0] m_line [NW];
  logic [LW-1:0] mem_data;

  assign bus.way_valid   = m_valid;
  assign bus.way_dirty   = m_dirty;
  assign bus.way_expired = m_expired;
  assign bus.way_w_ack   = bus.way_w_en;
  assign bus.mem_rline   = mem_data;

  for (genvar g = 0; g < NW; g++) begin : g_way
    assign bus.way_tag[g*TW +: TW]   = m_tag[g];
    assign bus.way_age[g*CW +: CW]   = m_age[g];
    assign bus.way_line[g*LW +: LW]  = m_line[g];
    assign bus.way_rdata[g*DW +: DW] = m_line[g][bus.way_offset*DW +: DW];
  end

  int            n_cmp, n_err;
  int            n_resp, resp_k, n_upd, n_mem;
  logic [DW-1:0] resp_data;
  logic [CW-1:0] upd_age;
  logic          upd_acc, wb_seen, rf_seen, unstable, ready_busy, rst_mem_req, rst_ready;
  logic [AW-1:0] wb_addr, rf_addr, alloc_addr;
  logic [LW-1:0] wb_line, alloc_line;
  logic [NW-1:0] alloc_vec, wen_vec;

  function automatic logic [LW-1:0] make_line(input logic [31:0] seed);
    logic [LW-1:0] l;
    l = '0;
    for (int w = 0; w < WORDS; w++) l[w*DW +: DW] = seed + 32'(w);
    return l;
  endfunction

  // Issues one request and plays CPU, way array and memory until the response plus two tail cycles.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input int ack_delay, input int budget, input logic poke, input logic rst_wb);
    int k, memcnt;
    logic [AW-1:0] ph_addr;
    logic [LW-1:0] ph_line;
    logic poked, skip;
    n_resp = 0; resp_k = 0; n_upd = 0; n_mem = 0; resp_data = '0; upd_age = '0; upd_acc = 0;
    wb_seen = 0; rf_seen = 0; unstable = 0; ready_busy = 0; rst_mem_req = 1'bx; rst_ready = 1'bx;
    wb_addr = '0; rf_addr = '0; alloc_addr = '0; wb_line = '0; alloc_line = '0; alloc_vec = '0; wen_vec = '0;
    ph_addr = '0; ph_line = '0;
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 0;
    k = 1; memcnt = 0; poked = 0;
    while (k <= budget && !(n_resp > 0 && k > resp_k + 2)) begin
      skip = 0;
      if (reset) reset = 1'b0;
      if (poke) begin
        if (!poked && bus.mem_req && !bus.mem_we) begin
          bus.req_valid = 1; bus.req_addr = 32'h999; poked = 1;
        end else bus.req_valid = 0;
      end
      if (rst_wb && bus.mem_req && bus.mem_we) begin
        wb_seen = 1; reset = 1'b1; bus.mem_ack = 1'b0; #1;
        rst_mem_req = bus.mem_req; rst_ready = bus.req_ready; skip = 1;
      end
      if (!skip) begin
        if (n_resp == 0 && bus.req_ready) ready_busy = 1;
        if (bus.resp_valid) begin
          n_resp++;
          if (n_resp == 1) begin resp_k = k; resp_data = bus.resp_rdata; end
        end
        if (bus.update_age) begin n_upd++; upd_age = bus.accessed_way_age; upd_acc = bus.accessed; end
        if (bus.mem_ack) memcnt = 0;
        if (bus.mem_req) begin
          memcnt++; n_mem++;
          if (memcnt == 1) begin ph_addr = bus.mem_addr; ph_line = bus.mem_wline; end
          else if (bus.mem_addr !== ph_addr || bus.mem_wline !== ph_line) unstable = 1;
          if (bus.mem_we) begin wb_seen = 1; wb_addr = bus.mem_addr; wb_line = bus.mem_wline; end
          else begin rf_seen = 1; rf_addr = bus.mem_addr; end
          bus.mem_ack = (memcnt > ack_delay);
        end else begin
          bus.mem_ack = 0; memcnt = 0;
        end
        for (int i = 0; i < NW; i++) begin
          if (bus.way_allocate[i]) begin
            alloc_vec[i] = 1; alloc_addr = bus.way_line_address; alloc_line = bus.way_fetched_line;
            m_valid[i] = 1; m_dirty[i] = 0; m_tag[i] = bus.way_line_address[AW-1:OW]; m_line[i] = bus.way_fetched_line;
          end
          if (bus.way_w_en[i]) begin
            wen_vec[i] = 1; m_dirty[i] = 1; m_line[i][bus.way_offset*DW +: DW] = bus.way_wdata;
          end
        end
      end
      @(negedge clk);
      k++;
    end
    bus.req_valid = 0; bus.mem_ack = 0; reset = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if ({bus.resp_valid, bus.mem_req, bus.mem_we, bus.update_age, bus.accessed} !== 5'b0) begin
      n_err++; $display("FAIL rst_strobes: got %b want 00000", {bus.resp_valid, bus.mem_req, bus.mem_we, bus.update_age, bus.accessed}); end
    n_cmp++; if ({bus.way_allocate, bus.way_w_en, bus.way_offset, bus.mem_addr, bus.way_wdata} !== '0) begin
      n_err++; $display("FAIL rst_buses: got nonzero alloc=%b wen=%b off=%h maddr=%h", bus.way_allocate, bus.way_w_en, bus.way_offset, bus.mem_addr); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_write_miss_then_read;
    mem_data = make_line(32'h1000);
    do_req(1'b1, 32'h104, 32'hDEADBEEF, 0, 30, 1'b0, 1'b0);
    n_cmp++; if (rf_addr !== 32'h100) begin n_err++; $display("FAIL wm_refill_addr: got %h want 00000100", rf_addr); end
    n_cmp++; if (wb_seen !== 1'b0) begin n_err++; $display("FAIL wm_no_writeback: got %b want 0", wb_seen); end
    n_cmp++; if (alloc_vec !== 4'b0001) begin n_err++; $display("FAIL wm_alloc: got %b want 0001", alloc_vec); end
    n_cmp++; if (alloc_addr !== 32'h100) begin n_err++; $display("FAIL wm_alloc_addr: got %h want 00000100", alloc_addr); end
    n_cmp++; if (alloc_line !== make_line(32'h1000)) begin n_err++; $display("FAIL wm_alloc_line: got %h", alloc_line); end
    n_cmp++; if (wen_vec !== 4'b0001) begin n_err++; $display("FAIL wm_wen: got %b want 0001", wen_vec); end
    n_cmp++; if (n_resp !== 1 || resp_k !== 6) begin n_err++; $display("FAIL wm_resp: got n=%0d k=%0d want n=1 k=6", n_resp, resp_k); end
    n_cmp++; if (resp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wm_resp_data: got %h want deadbeef", resp_data); end
    do_req(1'b0, 32'h104, 32'h0, 0, 10, 1'b0, 1'b0);
    n_cmp++; if (resp_k !== 2 || resp_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rd_after_wr: got k=%0d data=%h want k=2 data=deadbeef", resp_k, resp_data); end
  endtask

  task automatic test_read_hit_age;
    for (int i = 0; i < NW; i++) begin
      m_tag[i] = TW'(32'h10 + i); m_age[i] = CW'(i); m_line[i] = make_line(32'h2000 + 32'h100 * i);
    end
    m_valid = '1; m_dirty = '0; m_expired = '0;
    do_req(1'b0, 32'h95, 32'h0, 0, 10, 1'b0, 1'b0);
    n_cmp++; if (resp_k !== 2 || resp_data !== 32'h2205) begin
      n_err++; $display("FAIL hit_resp: got k=%0d data=%h want k=2 data=00002205", resp_k, resp_data); end
    n_cmp++; if (upd_age !== 2'd2 || upd_acc !== 1'b1) begin
      n_err++; $display("FAIL hit_age: got age=%0d acc=%b want age=2 acc=1", upd_age, upd_acc); end
    n_cmp++; if (n_upd !== 1 || n_resp !== 1) begin
      n_err++; $display("FAIL hit_pulses: got upd=%0d resp=%0d want 1 1", n_upd, n_resp); end
  endtask

  task automatic test_multi_hit;
    m_tag[3] = TW'(32'h11);
    do_req(1'b0, 32'h8A, 32'h0, 0, 10, 1'b0, 1'b0);
    n_cmp++; if (resp_data !== 32'h2102) begin n_err++; $display("FAIL multi_hit_data: got %h want 00002102", resp_data); end
    n_cmp++; if (upd_age !== 2'd1) begin n_err++; $display("FAIL multi_hit_age: got %0d want 1", upd_age); end
  endtask

  task automatic test_writeback;
    m_tag[3] = TW'(32'h7); m_dirty[3] = 1'b1; m_expired[3] = 1'b1;
    mem_data = make_line(32'h5000);
    do_req(1'b0, 32'h202, 32'h0, 0, 30, 1'b0, 1'b0);
    n_cmp++; if (wb_seen !== 1'b1 || wb_addr !== 32'h38) begin
      n_err++; $display("FAIL wb_addr: got seen=%b addr=%h want 1 00000038", wb_seen, wb_addr); end
    n_cmp++; if (wb_line !== make_line(32'h2300)) begin n_err++; $display("FAIL wb_line: got %h", wb_line); end
    n_cmp++; if (rf_addr !== 32'h200) begin n_err++; $display("FAIL wb_refill_addr: got %h want 00000200", rf_addr); end
    n_cmp++; if (alloc_vec !== 4'b1000) begin n_err++; $display("FAIL wb_alloc: got %b want 1000", alloc_vec); end
    n_cmp++; if (resp_k !== 6 || resp_data !== 32'h5002) begin
      n_err++; $display("FAIL wb_resp: got k=%0d data=%h want k=6 data=00005002", resp_k, resp_data); end
    n_cmp++; if (upd_age !== 2'd3) begin n_err++; $display("FAIL wb_age: got %0d want 3", upd_age); end
  endtask

  task automatic test_ack_delay;
    mem_data = make_line(32'h6000);
    do_req(1'b0, 32'h20B, 32'h0, 10, 40, 1'b0, 1'b0);
    n_cmp++; if (n_mem !== 11) begin n_err++; $display("FAIL dly_mem_cycles: got %0d want 11", n_mem); end
    n_cmp++; if (unstable !== 1'b0) begin n_err++; $display("FAIL dly_stable: got unstable=%b want 0", unstable); end
    n_cmp++; if (ready_busy !== 1'b0) begin n_err++; $display("FAIL dly_ready: got ready_seen=%b want 0", ready_busy); end
    n_cmp++; if (resp_k !== 15 || resp_data !== 32'h6003) begin
      n_err++; $display("FAIL dly_resp: got k=%0d data=%h want k=15 data=00006003", resp_k, resp_data); end
  endtask

  task automatic test_poke_refill;
    mem_data = make_line(32'h7000);
    do_req(1'b0, 32'h210, 32'h0, 3, 30, 1'b1, 1'b0);
    n_cmp++; if (n_resp !== 1) begin n_err++; $display("FAIL poke_resp_count: got %0d want 1", n_resp); end
    n_cmp++; if (rf_addr !== 32'h210 || unstable !== 1'b0) begin
      n_err++; $display("FAIL poke_refill_addr: got %h unstable=%b want 00000210 0", rf_addr, unstable); end
    n_cmp++; if (resp_k !== 8 || resp_data !== 32'h7000) begin
      n_err++; $display("FAIL poke_resp: got k=%0d data=%h want k=8 data=00007000", resp_k, resp_data); end
  endtask

  task automatic test_reset_in_writeback;
    m_dirty[3] = 1'b1;
    do_req(1'b0, 32'h218, 32'h0, 5, 10, 1'b0, 1'b1);
    n_cmp++; if (wb_seen !== 1'b1) begin n_err++; $display("FAIL rwb_reached: got %b want 1", wb_seen); end
    n_cmp++; if (rst_mem_req !== 1'b0 || rst_ready !== 1'b1) begin
      n_err++; $display("FAIL rwb_abort: got mem_req=%b ready=%b want 0 1", rst_mem_req, rst_ready); end
    n_cmp++; if (n_resp !== 0) begin n_err++; $display("FAIL rwb_no_resp: got %0d want 0", n_resp); end
  endtask

  task automatic test_back_to_back;
    do_req(1'b0, 32'h81, 32'h0, 0, 10, 1'b0, 1'b0);
    n_cmp++; if (resp_k !== 2 || resp_data !== 32'h2001) begin
      n_err++; $display("FAIL b2b_first: got k=%0d data=%h want k=2 data=00002001", resp_k, resp_data); end
    do_req(1'b0, 32'h8F, 32'h0, 0, 10, 1'b0, 1'b0);
    n_cmp++; if (resp_k !== 2 || resp_data !== 32'h2107) begin
      n_err++; $display("FAIL b2b_second: got k=%0d data=%h want k=2 data=00002107", resp_k, resp_data); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 0;
    mem_data = '0; m_valid = '0; m_dirty = '0; m_expired = '0;
    for (int i = 0; i < NW; i++) begin m_tag[i] = '0; m_age[i] = '0; m_line[i] = '0; end
    test_reset;
    test_write_miss_then_read;
    test_read_hit_age;
    test_multi_hit;
    test_writeback;
    test_ack_delay;
    test_poke_refill;
    test_reset_in_writeback;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cache_set_controller.md
CACHE_SET_CONTROLLER -- requirements
Module: cache_set_controller

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, number of ways in the set.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 SHALL have parameter BLOCK_SIZE, default 32, line size in bytes.
REQ-004 SHALL have parameter ADDRESS_WIDTH, default 32, word address width.
REQ-005 SHALL derive the following: WORDS = BLOCK_SIZE/(DATA_WIDTH/8); OW = clog2(WORDS); TW = ADDRESS_WIDTH-OW; CW = clog2(NUM_WAYS); LW = WORDS*DATA_WIDTH.
REQ-006 SHALL have the following ports (one clock; reset is asynchronous and active-high):
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid / req_ready  in / out  1  CPU request handshake
req_we  in  1  1 = write
req_addr  in  ADDRESS_WIDTH  word address; tag = [AW-1:OW], offset = [OW-1:0]
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_WIDTH  read data
way_valid, way_dirty, way_expired, way_w_ack  in  NUM_WAYS  per-way status
way_tag  in  NUM_WAYS*TW  per-way tags
way_age  in  NUM_WAYS*CW  per-way LRU ages
way_rdata  in  NUM_WAYS*DATA_WIDTH  per-way word at way_offset
way_line  in  NUM_WAYS*LW  per-way full line
way_allocate, way_w_en  out  NUM_WAYS  one-hot way strobes
way_offset  out  OW  word select
way_wdata  out  DATA_WIDTH  write word
way_line_address  out  ADDRESS_WIDTH  allocate address, offset bits zero
way_fetched_line  out  LW  refill data
update_age, accessed  out  1  age-update strobe, hit flag
accessed_way_age  out  CW  age of accessed way
mem_req, mem_we  out  1  memory request, write
mem_addr  out  ADDRESS_WIDTH  line address, offset zero
mem_wline  out  LW  writeback line
mem_ack  in  1  memory completion
mem_rline  in  LW  refill line

Function
REQ-007 SHALL implement the following FSM states: IDLE, LOOKUP, WRITE, WRITEBACK, REFILL, ALLOCATE, RESPOND.
REQ-008 IDLE SHALL behave as follows: req_ready=1 only in IDLE; req_valid&req_ready latches addr/we/wdata -> LOOKUP.
REQ-009 LOOKUP SHALL last 1 cycle: hit = way_valid[i] & way_tag[i]==latched tag; multiple hits -> lowest index.
REQ-010 On a read hit, the controller SHALL capture way_rdata[hit], pulse update_age=1 with accessed=1 and accessed_way_age=way_age[hit], and go -> RESPOND.
REQ-011 On a write hit, the controller SHALL go -> WRITE.
REQ-012 WRITE SHALL hold way_w_en[hit]=1 until way_w_ack[hit]=1, then drop w_en, pulse update_age as in REQ-010, and go -> RESPOND.
REQ-013 On a miss, the victim SHALL be the lowest-index invalid way, else the lowest-index way_expired way, else way 0.
REQ-014 From a miss, the next state SHALL be WRITEBACK if the victim is valid and dirty, else REFILL.
REQ-015 WRITEBACK SHALL drive mem_req=1, mem_we=1, mem_addr={victim tag, OW'0}, mem_wline=way_line[victim] stable until mem_ack, then go -> REFILL.
REQ-016 REFILL SHALL drive mem_req=1, mem_we=0, mem_addr={request tag, OW'0}; on mem_ack, register mem_rline and go -> ALLOCATE.
REQ-017 A mem_ack in the first cycle of mem_req SHALL be honoured; mem_ack outside WRITEBACK/REFILL SHALL be ignored.
REQ-018 ALLOCATE SHALL pulse way_allocate[victim] for 1 cycle with way_line_address={request tag, OW'0} and way_fetched_line=the registered line, then go -> LOOKUP (replay; guaranteed hit).
REQ-019 RESPOND SHALL pulse resp_valid for 1 cycle, with resp_rdata = read data (read) or req_wdata (write), then go -> IDLE.
REQ-020 way_offset and way_wdata SHALL reflect the latched request in every state other than IDLE.
REQ-021 Latency from acceptance SHALL be: read hit, resp_valid at cycle +2; write hit, +2 plus ack wait; miss, adds memory cycles +1 ALLOCATE +1 LOOKUP.
REQ-022 At most one request SHALL be outstanding; req_valid while req_ready=0 SHALL have no effect.

Reset
REQ-023 Reset SHALL force state=IDLE and all outputs to 0 except req_ready=1; the latched request and line register SHALL be cleared.
REQ-024 Reset asserted mid-operation SHALL abort immediately, drop mem_req, and produce no resp_valid for the aborted request.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Write 0xDEADBEEF to addr 0x104 when all ways are invalid -> REFILL mem_addr=0x100, allocate way 0, way_w_en[0], resp_valid; then read 0x104 -> resp_rdata=0xDEADBEEF at +2 cycles.
- Read hit on way 2 with ages {0,1,2,3} -> update_age=1, accessed_way_age=2, single-cycle pulse.
- Full set, way 3 expired and dirty, tag 0x7 -> WRITEBACK mem_we=1 mem_addr=0x38 with way_line[3], then REFILL, way_allocate=4'b1000.
- mem_ack held low 10 cycles -> mem_req stays 1, outputs stable, req_ready=0 throughout.
- req_valid pulsed during REFILL -> ignored, no second response.
- Reset asserted in WRITEBACK -> mem_req=0 and req_ready=1 immediately, no resp_valid.
